// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel arbitrated multiplexer feeding a single registered output stage.
//   A round-robin (RR=1) or fixed-priority (RR=0, lowest index wins) arbiter picks one
//   valid input per cycle and loads it into the output register whenever that register
//   is empty or draining.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    N*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel offer
//   in_ready   per-channel accept (combinational from in_valid/out_ready/out_valid)
//   out_data   registered selected data
//   out_sel    index of the channel that supplied out_data
//   out_valid  output register holds data
//   out_ready  sink accepts this cycle
module rr_mux_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned RR    = 1,
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  base;
    logic [SELW-1:0]  gsel;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] gdata;
    logic             found;
    logic             ld;

    // Fixed priority is round-robin with the search start pinned at channel 0.
    assign base = (RR != 0) ? ptr : '0;

    // Output register can take a new word when empty or draining; reset blocks all transfers.
    assign ld = (~out_valid | out_ready) & ~reset;

    // Grant search: first pass covers channels base..N-1, second pass wraps to 0..base-1.
    always_comb begin
        grant = '0;
        gsel  = '0;
        gdata = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && in_valid[i] && (SELW'(i) >= base)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gsel     = SELW'(i);
                gdata    = in_data[i*WIDTH +: WIDTH];
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && in_valid[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                gsel     = SELW'(i);
                gdata    = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = grant & {N{ld}};

    // Output register and arbitration pointer; pointer only moves on an actual load.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (ld) begin
            if (found) begin
                out_data  <= gdata;
                out_sel   <= gsel;
                out_valid <= 1'b1;
                if (RR != 0) begin
                    // Wrap at N so non-power-of-two channel counts never point past the end.
                    ptr <= (gsel == SELW'(N - 1)) ? '0 : gsel + SELW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
